// File: rtl/if_tracker_mo.sv
// Instruction-fetch trace tracker: timestamps req/grant/rvalid of in-order pipelined fetches.
// Optional IF_TRACKER_STATS_EN adds the saturating drop_count output.
package if_tracker_mo_pkg;

    typedef struct packed {
        logic [31:0] time_start;
        logic [31:0] time_end;
    } trace_span_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instruction;
        trace_span_t if_data;
        trace_span_t mem_access_req;
        trace_span_t mem_access_res;
    } trace_output;

endpackage

module if_tracker_mo
    import if_tracker_mo_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int OUT_DEPTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req,
    input  logic [ADDR_WIDTH-1:0] instr_addr,
    input  logic                  instr_grant,
    input  logic                  instr_rvalid,
    input  logic [DATA_WIDTH-1:0] instr_rdata,
    input  integer                counter,
    input  logic                  if_data_ready,
    output logic                  if_data_valid,
    output trace_output           if_data_o,
    output logic                  proto_err
`ifdef IF_TRACKER_STATS_EN
    ,
    output logic [15:0]           drop_count
`endif
);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] t_req;
        logic [31:0] t_grant;
    } inflight_t;

    // A depth-1 in-flight queue still uses a 1-bit index; the spare slot is harmless.
    localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OW = $clog2(OUT_DEPTH);
    localparam logic [IW:0] IF_CAP = (IW+1)'(MAX_OUTSTANDING);

    inflight_t   if_mem [0:(2**IW)-1];
    logic [IW:0] if_wr;
    logic [IW:0] if_rd;
    logic [IW:0] if_used;

    trace_output out_mem [0:OUT_DEPTH-1];
    logic [OW:0] out_wr;
    logic [OW:0] out_rd;

    logic        req_open;
    logic [31:0] req_start;
    logic [31:0] now;
    logic [31:0] start_time;

    logic        if_empty;
    logic        if_full;
    logic        out_empty;
    logic        out_full;
    logic        grant_fire;
    logic        if_pop;
    logic        if_push;
    logic        out_pop;
    logic        out_push;
    inflight_t   if_head;
    trace_output done_rec;

    always_comb begin
        now        = counter;
        start_time = req_open ? req_start : now;
        if_used    = if_wr - if_rd;
        if_empty   = (if_wr == if_rd);
        if_full    = (if_used == IF_CAP);
        out_empty  = (out_wr == out_rd);
        out_full   = (out_wr[OW] != out_rd[OW]) && (out_wr[OW-1:0] == out_rd[OW-1:0]);
        grant_fire = instr_req && instr_grant;
        if_pop     = instr_rvalid && !if_empty;
        // A same-cycle response frees the slot the new grant needs.
        if_push    = grant_fire && (!if_full || if_pop);
        out_pop    = !out_empty && if_data_ready;
        out_push   = if_pop && (!out_full || out_pop);
        if_head    = if_mem[if_rd[IW-1:0]];

        done_rec                           = '0;
        done_rec.addr                      = if_head.addr;
        done_rec.instruction               = 32'(instr_rdata);
        done_rec.if_data.time_start        = if_head.t_req;
        done_rec.if_data.time_end          = now;
        done_rec.mem_access_req.time_start = if_head.t_req;
        done_rec.mem_access_req.time_end   = if_head.t_grant;
        done_rec.mem_access_res.time_start = if_head.t_grant;
        done_rec.mem_access_res.time_end   = now;
    end

    assign if_data_valid = !out_empty;
    assign if_data_o     = out_empty ? '0 : out_mem[out_rd[OW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_open  <= 1'b0;
            req_start <= '0;
            if_wr     <= '0;
            if_rd     <= '0;
            out_wr    <= '0;
            out_rd    <= '0;
            proto_err <= 1'b0;
        end else begin
            if (grant_fire) begin
                req_open <= 1'b0;
            end else if (instr_req && !req_open) begin
                req_open  <= 1'b1;
                req_start <= now;
            end

            if (if_pop)  if_rd  <= if_rd + 1'b1;
            if (if_push) if_wr  <= if_wr + 1'b1;
            if (out_pop)  out_rd <= out_rd + 1'b1;
            if (out_push) out_wr <= out_wr + 1'b1;

            if ((instr_rvalid && if_empty) || (grant_fire && !if_push))
                proto_err <= 1'b1;
        end
    end

    // Storage arrays carry no reset; pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (if_push) begin
            if_mem[if_wr[IW-1:0]] <= '{addr: 32'(instr_addr), t_req: start_time, t_grant: now};
        end
        if (out_push) begin
            out_mem[out_wr[OW-1:0]] <= done_rec;
        end
    end

`ifdef IF_TRACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (if_pop && !out_push && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_tracker_mo.sv
// Self-checking bench for if_tracker_mo: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_if_tracker_mo;
    import if_tracker_mo_pkg::*;

    localparam int MAXO = 2;
    localparam int ODEP = 4;

    logic        clk;
    logic        rst_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_grant;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    integer      counter;
    logic        if_data_ready;
    logic        if_data_valid;
    trace_output if_data_o;
    logic        proto_err;
`ifdef IF_TRACKER_STATS_EN
    logic [15:0] drop_count;
`endif

    int checks;
    int errors;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ts;
        logic [31:0] tg;
    } fl_t;

    fl_t         flq[$];
    trace_output outq[$];
    bit          m_open;
    logic [31:0] m_start;
    bit          m_perr;
    int          m_drop;

    if_tracker_mo #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO), .OUT_DEPTH(ODEP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_grant(instr_grant),
        .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .counter(counter),
        .if_data_ready(if_data_ready), .if_data_valid(if_data_valid),
        .if_data_o(if_data_o), .proto_err(proto_err)
`ifdef IF_TRACKER_STATS_EN
        , .drop_count(drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic trace_output mkrec(logic [31:0] a, logic [31:0] ins,
                                          logic [31:0] ifs, logic [31:0] ife,
                                          logic [31:0] rqs, logic [31:0] rqe,
                                          logic [31:0] rss, logic [31:0] rse);
        trace_output r;
        r = '0;
        r.addr = a; r.instruction = ins;
        r.if_data.time_start = ifs;        r.if_data.time_end = ife;
        r.mem_access_req.time_start = rqs; r.mem_access_req.time_end = rqe;
        r.mem_access_res.time_start = rss; r.mem_access_res.time_end = rse;
        return r;
    endfunction

    task automatic check(string tag, logic [255:0] obs, logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        flq.delete();
        outq.delete();
        m_open = 0; m_start = '0; m_perr = 0; m_drop = 0;
    endtask

    // Applies the fetch-tracking rules to the inputs present before the coming edge.
    task automatic model_cycle();
        logic [31:0] st;
        bit          popi;
        bit          popo;
        trace_output rec;
        fl_t         e;
        rec  = '0;
        st   = m_open ? m_start : counter;
        popi = instr_rvalid && (flq.size() > 0);
        popo = (outq.size() > 0) && if_data_ready;
        if (instr_rvalid && flq.size() == 0) m_perr = 1;
        if (popi) begin
            e = flq.pop_front();
            rec = mkrec(e.addr, instr_rdata, e.ts, counter, e.ts, e.tg, e.tg, counter);
        end
        if (instr_req && instr_grant) begin
            if (flq.size() < MAXO) flq.push_back('{instr_addr, st, counter});
            else m_perr = 1;
        end
        if (popo) void'(outq.pop_front());
        if (popi) begin
            if (outq.size() < ODEP) outq.push_back(rec);
            else if (m_drop < 65535) m_drop++;
        end
        if (instr_req && instr_grant) m_open = 0;
        else if (instr_req && !m_open) begin
            m_open = 1; m_start = counter;
        end
    endtask

    task automatic check_model();
        check("valid", 256'(if_data_valid), 256'(outq.size() != 0));
        if (outq.size() != 0) check("head", 256'(if_data_o), 256'(outq[0]));
        check("proto_err", 256'(proto_err), 256'(m_perr));
`ifdef IF_TRACKER_STATS_EN
        check("drop_count", 256'(drop_count), 256'(m_drop));
`endif
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        check_model();
        counter = counter + 1;
    endtask

    task automatic idle_inputs();
        instr_req = 0; instr_grant = 0; instr_rvalid = 0;
        instr_addr = '0; instr_rdata = '0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        #1;
        check("rst_valid", 256'(if_data_valid), 256'(0));
        check("rst_head", 256'(if_data_o), 256'(0));
        check("rst_perr", 256'(proto_err), 256'(0));
`ifdef IF_TRACKER_STATS_EN
        check("rst_drop", 256'(drop_count), 256'(0));
`endif
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        counter = 0;
        if_data_ready = 1;
        rst_n = 0;
        idle_inputs();
        model_reset();
        #2;
        do_reset();

        // Single fetch
        counter = 10; if_data_ready = 1;
        instr_req = 1; step();
        step();
        instr_grant = 1; instr_addr = 32'h100; step();
        idle_inputs(); step();
        instr_rvalid = 1; instr_rdata = 32'h13; step();
        check("single_valid", 256'(if_data_valid), 256'(1));
        check("single_rec", 256'(if_data_o), 256'(mkrec(32'h100, 32'h13, 10, 14, 10, 12, 12, 14)));
        idle_inputs(); step();
        check("single_once", 256'(if_data_valid), 256'(0));

        // Pipelined
        counter = 20;
        instr_req = 1; instr_grant = 1; instr_addr = 32'h200; step();
        instr_addr = 32'h204; step();
        idle_inputs(); instr_rvalid = 1; instr_rdata = 32'hA; step();
        check("pipe_rec0", 256'(if_data_o), 256'(mkrec(32'h200, 32'hA, 20, 22, 20, 20, 20, 22)));
        instr_rdata = 32'hB; step();
        check("pipe_rec1", 256'(if_data_o), 256'(mkrec(32'h204, 32'hB, 21, 23, 21, 21, 21, 23)));
        idle_inputs(); step();

        // Backpressure
        do_reset();
        if_data_ready = 0;
        for (int i = 0; i < 5; i++) begin
            instr_req = 1; instr_grant = 1; instr_addr = 32'h300 + 32'(4 * i); step();
            idle_inputs(); instr_rvalid = 1; instr_rdata = 32'(i); step();
        end
        idle_inputs();
`ifdef IF_TRACKER_STATS_EN
        check("bp_drop", 256'(drop_count), 256'(1));
`endif
        if_data_ready = 1;
        for (int k = 0; k < 4; k++) begin
            check("bp_order", 256'(if_data_o.addr), 256'(32'h300 + 32'(4 * k)));
            step();
        end
        check("bp_drained", 256'(if_data_valid), 256'(0));

        // Protocol errors
        do_reset();
        instr_rvalid = 1; step();
        idle_inputs();
        check("perr_rvalid", 256'(proto_err), 256'(1));
        check("perr_rvalid_noout", 256'(if_data_valid), 256'(0));
        do_reset();
        instr_req = 1; instr_grant = 1;
        for (int i = 0; i < 3; i++) begin
            instr_addr = 32'h400 + 32'(4 * i); step();
        end
        idle_inputs();
        check("perr_grant", 256'(proto_err), 256'(1));
        instr_rvalid = 1; step(); step();
        idle_inputs(); step();

        // Reset mid-operation
        do_reset();
        if_data_ready = 0;
        instr_req = 1; instr_grant = 1; instr_addr = 32'h500; step();
        idle_inputs(); instr_rvalid = 1; instr_rdata = 32'h55; step();
        idle_inputs(); instr_req = 1; instr_grant = 1; instr_addr = 32'h504; step();
        instr_addr = 32'h508; step();
        idle_inputs();
        #2;
        rst_n = 0;
        #1;
        check("midrst_valid", 256'(if_data_valid), 256'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        if_data_ready = 1;
        instr_rvalid = 1; step(); step();
        idle_inputs();
        check("midrst_perr", 256'(proto_err), 256'(1));
        check("midrst_noout", 256'(if_data_valid), 256'(0));

        // Random traffic, unconstrained
        do_reset();
        for (int i = 0; i < 300; i++) begin
            instr_req     = ($urandom_range(0, 3) != 0);
            instr_grant   = ($urandom_range(0, 1) != 0);
            instr_addr    = $urandom;
            instr_rvalid  = ($urandom_range(0, 2) == 0);
            instr_rdata   = $urandom;
            if_data_ready = ($urandom_range(0, 2) != 0);
            step();
        end

        // Random traffic, protocol-clean with heavy backpressure
        do_reset();
        for (int i = 0; i < 400; i++) begin
            instr_req     = ($urandom_range(0, 3) != 0);
            instr_grant   = ($urandom_range(0, 1) != 0) && (flq.size() < MAXO);
            instr_addr    = $urandom;
            instr_rvalid  = (flq.size() > 0) && ($urandom_range(0, 1) != 0);
            instr_rdata   = $urandom;
            if_data_ready = ($urandom_range(0, 3) == 0) || (i > 350);
            step();
        end
        check("clean_perr", 256'(proto_err), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
